// File: rtl/alu_uart_interface.sv
// Byte-stream front end for an ALU: collects A, B and opcode bytes, waits out the ALU latency, then ships the result.
// Optional inter-byte timeout is compiled in with the IFACE_TIMEOUT_EN macro.
module alu_uart_interface #(
   parameter int DATA_BITS      = 8,
   parameter int OP_BITS        = 6,
   parameter int ALU_LATENCY    = 1,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] i_rx_data,
   input  logic                 i_rx_done,
   input  logic [DATA_BITS-1:0] i_alu_result,
   output logic [DATA_BITS-1:0] o_alu_a,
   output logic [DATA_BITS-1:0] o_alu_b,
   output logic [OP_BITS-1:0]   o_alu_op,
   output logic [DATA_BITS-1:0] o_tx_data,
   output logic                 o_tx_start,
   input  logic                 i_tx_done,
   output logic                 o_busy,
   output logic                 o_timeout
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_WAIT = 3'd3,
      S_SEND = 3'd4,
      S_TXW  = 3'd5
   } state_t;

   localparam int WAIT_W = $clog2(ALU_LATENCY + 2);

   state_t                 state_q, state_d;
   logic [WAIT_W-1:0]      wait_q, wait_d;
   logic [DATA_BITS-1:0]   a_q, a_d, b_q, b_d, txData_q, txData_d;
   logic [OP_BITS-1:0]     op_q, op_d;
   logic                   txStart_q, txStart_d, busy_q, busy_d, timeout_q, timeout_d;

`ifdef IFACE_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [IDLE_W-1:0]      idle_q, idle_d;
`endif

   // Next-state and datapath capture; the wait counter is loaded so the result is
   // sampled once the ALU has had its full latency after the opcode lands.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      txData_d  = txData_q;
      timeout_d = 1'b0;
`ifdef IFACE_TIMEOUT_EN
      idle_d    = '0;
`endif
      case (state_q)
         S_A: begin
            if (i_rx_done) begin
               a_d     = i_rx_data;
               state_d = S_B;
            end
         end
         S_B: begin
            if (i_rx_done) begin
               b_d     = i_rx_data;
               state_d = S_OP;
            end
`ifdef IFACE_TIMEOUT_EN
            else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
               state_d   = S_A;
               timeout_d = 1'b1;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
`endif
         end
         S_OP: begin
            if (i_rx_done) begin
               op_d    = i_rx_data[OP_BITS-1:0];
               wait_d  = WAIT_W'(ALU_LATENCY + 1);
               state_d = S_WAIT;
            end
`ifdef IFACE_TIMEOUT_EN
            else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
               state_d   = S_A;
               timeout_d = 1'b1;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
`endif
         end
         S_WAIT: begin
            if (wait_q == '0) begin
               txData_d = i_alu_result;
               state_d  = S_SEND;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         S_SEND: state_d = S_TXW;
         S_TXW: begin
            if (i_tx_done) begin
               state_d = S_A;
            end
         end
         default: state_d = S_A;
      endcase
   end

   // Start and busy are registered from the next state so they line up with the state register.
   assign txStart_d = (state_d == S_SEND);
   assign busy_d    = (state_d == S_WAIT) || (state_d == S_SEND) || (state_d == S_TXW);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_A;
         wait_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         txData_q  <= '0;
         txStart_q <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
`ifdef IFACE_TIMEOUT_EN
         idle_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         txData_q  <= txData_d;
         txStart_q <= txStart_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
`ifdef IFACE_TIMEOUT_EN
         idle_q    <= idle_d;
`endif
      end
   end

   assign o_alu_a    = a_q;
   assign o_alu_b    = b_q;
   assign o_alu_op   = op_q;
   assign o_tx_data  = txData_q;
   assign o_tx_start = txStart_q;
   assign o_busy     = busy_q;
   assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Scoreboard bench for alu_uart_interface: a registered-ALU instance and a combinational-ALU instance share one byte stream.
// Build with or without IFACE_TIMEOUT_EN; the timeout expectations follow the macro.
module tb_alu_uart_interface;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rxData = 8'h00;
   logic       rxDone = 1'b0;
   logic       txDone = 1'b0;

   logic [7:0] a1, b1, txData1, alu1Res;
   logic [5:0] op1;
   logic       txStart1, busy1, timeout1;
   logic [7:0] a0, b0, txData0, alu0Res;
   logic [5:0] op0;
   logic       txStart0, busy0, timeout0;

   int cycleCnt    = 0;
   int opEdge      = 0;
   int testsRun    = 0;
   int testsFailed = 0;
   int toCount1    = 0;
   int toCount0    = 0;
   logic [7:0] q1[$];
   logic [7:0] q0[$];

   alu_uart_interface #(.ALU_LATENCY(1), .TIMEOUT_CYCLES(16)) dut1 (
      .clock(clock), .reset(reset), .i_rx_data(rxData), .i_rx_done(rxDone),
      .i_alu_result(alu1Res), .o_alu_a(a1), .o_alu_b(b1), .o_alu_op(op1),
      .o_tx_data(txData1), .o_tx_start(txStart1), .i_tx_done(txDone),
      .o_busy(busy1), .o_timeout(timeout1));

   alu_uart_interface #(.ALU_LATENCY(0), .TIMEOUT_CYCLES(16)) dut0 (
      .clock(clock), .reset(reset), .i_rx_data(rxData), .i_rx_done(rxDone),
      .i_alu_result(alu0Res), .o_alu_a(a0), .o_alu_b(b0), .o_alu_op(op0),
      .o_tx_data(txData0), .o_tx_start(txStart0), .i_tx_done(txDone),
      .o_busy(busy0), .o_timeout(timeout0));

   always #5 clock = ~clock;

   always @(posedge clock) cycleCnt <= cycleCnt + 1;

   function automatic logic [7:0] aluFunc(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         default: return a ^ b;
      endcase
   endfunction

   // External ALUs: one with a single register stage, one purely combinational.
   always @(posedge clock) alu1Res <= aluFunc(a1, b1, op1);
   assign alu0Res = aluFunc(a0, b0, op0);

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Each start pulse pops one expected result and checks its distance from the opcode edge.
   always @(negedge clock) begin
      if (!reset && txStart1) begin
         if (q1.size() == 0) begin
            checkOutput("tx1_extraStart", {31'b0, txStart1}, 32'd0);
         end else begin
            checkOutput("tx1_data", {24'b0, txData1}, {24'b0, q1[0]});
            checkOutput("tx1_latency", cycleCnt - opEdge, 32'd3);
            void'(q1.pop_front());
         end
      end
      if (!reset && txStart0) begin
         if (q0.size() == 0) begin
            checkOutput("tx0_extraStart", {31'b0, txStart0}, 32'd0);
         end else begin
            checkOutput("tx0_data", {24'b0, txData0}, {24'b0, q0[0]});
            checkOutput("tx0_latency", cycleCnt - opEdge, 32'd2);
            void'(q0.pop_front());
         end
      end
      if (!reset && timeout1) toCount1++;
      if (!reset && timeout0) toCount0++;
   end

   task automatic applyStimulus(input logic [7:0] b, input bit isOp, input bit withTxDone);
      @(negedge clock);
      rxData = b;
      rxDone = 1'b1;
      txDone = withTxDone;
      @(posedge clock);
      #1;
      rxDone = 1'b0;
      txDone = 1'b0;
      if (isOp) opEdge = cycleCnt;
   endtask

   task automatic pulseTxDone();
      @(negedge clock);
      txDone = 1'b1;
      @(posedge clock);
      #1;
      txDone = 1'b0;
   endtask

   task automatic checkCleared(input string tag);
      checkOutput({tag, "_a"},       {24'b0, a1},       32'd0);
      checkOutput({tag, "_b"},       {24'b0, b1},       32'd0);
      checkOutput({tag, "_op"},      {26'b0, op1},      32'd0);
      checkOutput({tag, "_txData"},  {24'b0, txData1},  32'd0);
      checkOutput({tag, "_txStart"}, {31'b0, txStart1}, 32'd0);
      checkOutput({tag, "_busy"},    {31'b0, busy1},    32'd0);
      checkOutput({tag, "_timeout"}, {31'b0, timeout1}, 32'd0);
      checkOutput({tag, "_a0"},      {24'b0, a0},       32'd0);
      checkOutput({tag, "_busy0"},   {31'b0, busy0},    32'd0);
   endtask

   task automatic finishTransaction(input string tag);
      repeat (6) @(negedge clock);
      checkOutput({tag, "_busyHeld"}, {31'b0, busy1}, 32'd1);
      pulseTxDone();
      checkOutput({tag, "_busyDrop1"}, {31'b0, busy1}, 32'd0);
      checkOutput({tag, "_busyDrop0"}, {31'b0, busy0}, 32'd0);
      checkOutput({tag, "_pending1"}, q1.size(), 32'd0);
      checkOutput({tag, "_pending0"}, q0.size(), 32'd0);
   endtask

   task automatic runTransaction(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      applyStimulus(a, 1'b0, 1'b0);
      applyStimulus(b, 1'b0, 1'b0);
      q1.push_back(aluFunc(a, b, op[5:0]));
      q0.push_back(aluFunc(a, b, op[5:0]));
      applyStimulus(op, 1'b1, 1'b0);
      checkOutput({tag, "_a"},    {24'b0, a1},    {24'b0, a});
      checkOutput({tag, "_b"},    {24'b0, b1},    {24'b0, b});
      checkOutput({tag, "_op"},   {26'b0, op1},   {26'b0, op[5:0]});
      checkOutput({tag, "_op0"},  {26'b0, op0},   {26'b0, op[5:0]});
      checkOutput({tag, "_busy"}, {31'b0, busy1}, 32'd1);
      finishTransaction(tag);
   endtask

   initial begin
      #3;
      checkCleared("por");
      @(negedge clock);
      reset = 1'b0;

      runTransaction("add", 8'h05, 8'h03, 8'h20);

      // Asynchronous reset while idle with non-zero operands held.
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      checkCleared("idleRst");
      @(negedge clock);
      reset = 1'b0;

      runTransaction("sub", 8'h03, 8'h05, 8'hE2);

      // Stray bytes during the wait and coincident with tx done are dropped.
      applyStimulus(8'h0C, 1'b0, 1'b0);
      applyStimulus(8'h04, 1'b0, 1'b0);
      q1.push_back(aluFunc(8'h0C, 8'h04, 6'h20));
      q0.push_back(aluFunc(8'h0C, 8'h04, 6'h20));
      applyStimulus(8'h20, 1'b1, 1'b0);
      applyStimulus(8'h55, 1'b0, 1'b0);
      checkOutput("stray_waitA", {24'b0, a1}, 32'h0C);
      checkOutput("stray_waitB", {24'b0, b1}, 32'h04);
      checkOutput("stray_waitBusy", {31'b0, busy1}, 32'd1);
      repeat (5) @(negedge clock);
      applyStimulus(8'h55, 1'b0, 1'b1);
      checkOutput("stray_txwBusy1", {31'b0, busy1}, 32'd0);
      checkOutput("stray_txwBusy0", {31'b0, busy0}, 32'd0);
      checkOutput("stray_txwA", {24'b0, a1}, 32'h0C);
      runTransaction("afterStray", 8'h11, 8'h22, 8'h0A);

      // Reset while waiting for the transmitter.
      applyStimulus(8'h01, 1'b0, 1'b0);
      applyStimulus(8'h02, 1'b0, 1'b0);
      q1.push_back(aluFunc(8'h01, 8'h02, 6'h20));
      q0.push_back(aluFunc(8'h01, 8'h02, 6'h20));
      applyStimulus(8'h20, 1'b1, 1'b0);
      repeat (6) @(negedge clock);
      checkOutput("txwRst_pre", {31'b0, busy1}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("txwRst_start", {31'b0, txStart1}, 32'd0);
      checkOutput("txwRst_busy", {31'b0, busy1}, 32'd0);
      checkOutput("txwRst_txData", {24'b0, txData1}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Reset in the middle of the start pulse.
      applyStimulus(8'h04, 1'b0, 1'b0);
      applyStimulus(8'h05, 1'b0, 1'b0);
      q1.push_back(aluFunc(8'h04, 8'h05, 6'h20));
      q0.push_back(aluFunc(8'h04, 8'h05, 6'h20));
      applyStimulus(8'h20, 1'b1, 1'b0);
      repeat (3) @(posedge clock);
      #2;
      checkOutput("sendRst_pre", {31'b0, txStart1}, 32'd1);
      checkOutput("sendRst_preData", {24'b0, txData1}, 32'h09);
      reset = 1'b1;
      #1;
      checkOutput("sendRst_start", {31'b0, txStart1}, 32'd0);
      checkOutput("sendRst_txData", {24'b0, txData1}, 32'd0);
      checkOutput("sendRst_busy", {31'b0, busy1}, 32'd0);
      q1.delete();
      q0.delete();
      @(negedge clock);
      reset = 1'b0;

      // Inter-byte idle of 16 cycles after operand A.
      toCount1 = 0;
      toCount0 = 0;
      applyStimulus(8'h07, 1'b0, 1'b0);
      repeat (15) @(negedge clock);
      checkOutput("to_early1", toCount1, 32'd0);
      repeat (3) @(negedge clock);
`ifdef IFACE_TIMEOUT_EN
      checkOutput("to_pulse1", toCount1, 32'd1);
      checkOutput("to_pulse0", toCount0, 32'd1);
      checkOutput("to_keepA", {24'b0, a1}, 32'h07);
      applyStimulus(8'h09, 1'b0, 1'b0);
      checkOutput("to_nextA", {24'b0, a1}, 32'h09);
      applyStimulus(8'h0A, 1'b0, 1'b0);
      q1.push_back(aluFunc(8'h09, 8'h0A, 6'h20));
      q0.push_back(aluFunc(8'h09, 8'h0A, 6'h20));
`else
      checkOutput("to_pulse1", toCount1, 32'd0);
      checkOutput("to_pulse0", toCount0, 32'd0);
      applyStimulus(8'h09, 1'b0, 1'b0);
      checkOutput("to_nextB", {24'b0, b1}, 32'h09);
      checkOutput("to_keepA", {24'b0, a1}, 32'h07);
      q1.push_back(aluFunc(8'h07, 8'h09, 6'h20));
      q0.push_back(aluFunc(8'h07, 8'h09, 6'h20));
`endif
      applyStimulus(8'h20, 1'b1, 1'b0);
      finishTransaction("toTail");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
